// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the baud-divider calculation used by both receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick, truncated.
  function automatic int calc_tick_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable divider producing a one-clock tick every DIV clocks; restart
// re-phases the tick so the next one lands DIV clocks later.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampled, with a valid/ack
// holding register plus framing and overrun reporting.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD);

  logic rx_meta, rx_s, rx_d;
  logic tick, restart;

  state_t state, state_next;
  logic [3:0] s_cnt, s_cnt_next;
  logic [2:0] b_cnt, b_cnt_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic load_byte, set_overrun, frame_err_next;

  uart_baud_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Two flops for metastability, a third to spot the falling start edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      s_cnt <= '0;
      b_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      s_cnt <= s_cnt_next;
      b_cnt <= b_cnt_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next     = state;
    s_cnt_next     = s_cnt;
    b_cnt_next     = b_cnt;
    shreg_next     = shreg;
    restart        = 1'b0;
    load_byte      = 1'b0;
    set_overrun    = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_next = START;
          s_cnt_next = '0;
          restart    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == 4'(MID_SAMPLE)) begin
            s_cnt_next = '0;
            b_cnt_next = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end
      // Right shift so the first (LSB) bit ends up in shreg[0].
      DATA: begin
        if (tick) begin
          if (s_cnt == 4'(OVERSAMPLE - 1)) begin
            shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
            s_cnt_next = '0;
            if (b_cnt == 3'(DATA_BITS - 1)) begin
              state_next = STOP;
            end else begin
              b_cnt_next = b_cnt + 3'd1;
            end
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt == 4'(OVERSAMPLE - 1)) begin
            state_next = IDLE;
            s_cnt_next = '0;
            if (!rx_s) begin
              frame_err_next = 1'b1;
            end else if (!data_valid || data_ack) begin
              load_byte = 1'b1;
            end else begin
              set_overrun = 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A byte loaded on the ack clock wins over the ack's clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= frame_err_next;
      if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (load_byte) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench: directed scenarios plus random frames, compared against
// a per-frame behavioural model of the receiver's output register.
module tb_uart_rx_deframer;

  localparam int CLK_FREQ     = 1_600_000;
  localparam int BAUD         = 10_000;
  localparam int CLKS_PER_BIT = 160;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;
  localparam int LATENCY      = CLKS_PER_BIT * 19 / 2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int check_count = 0;
  int pass_count  = 0;

  int cyc = 0;
  int frame_start_cyc = 0;
  int fe_cycles = 0;
  int valid_rises = 0;
  int valid_rise_cyc = -1;
  int busy_cycles = 0;
  logic prev_valid = 1'b0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_overrun = 1'b0;
  int         exp_fe_frame = 0;
  int         exp_rise_frame = 0;

  uart_rx_deframer #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (frame_err) fe_cycles++;
    if (data_valid && !prev_valid) begin
      valid_rises++;
      valid_rise_cyc = cyc;
    end
    prev_valid = data_valid;
    if (rx_busy) busy_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clearMonitor();
    fe_cycles      = 0;
    valid_rises    = 0;
    valid_rise_cyc = -1;
    busy_cycles    = 0;
  endtask

  task automatic idleClocks(input int n, input logic level);
    rx = level;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame cycle by cycle; optionally acks on the completion clock.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_bit,
                               input bit ack_at_done, input int len);
    frame_start_cyc = cyc;
    for (int c = 0; c < len; c++) begin
      int bit_idx;
      bit_idx = c / CLKS_PER_BIT;
      if (bit_idx == 0) rx = 1'b0;
      else if (bit_idx <= 8) rx = b[bit_idx-1];
      else rx = stop_bit;
      data_ack = ack_at_done && (c == LATENCY - 1);
      @(posedge clk);
      #1;
    end
    data_ack = 1'b0;
  endtask

  task automatic modelFrame(input logic [7:0] b, input bit stop_ok, input bit ack_now);
    exp_fe_frame   = 0;
    exp_rise_frame = 0;
    if (stop_ok) begin
      if (!exp_valid) begin
        exp_data       = b;
        exp_valid      = 1'b1;
        exp_rise_frame = 1;
      end else if (ack_now) begin
        exp_data    = b;
        exp_overrun = 1'b0;
      end else begin
        exp_overrun = 1'b1;
      end
    end else begin
      exp_fe_frame = 1;
      if (ack_now && exp_valid) begin
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
      end
    end
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, ".data"}, 32'(data_out), 32'(exp_data));
    checkOutput({tag, ".valid"}, 32'(data_valid), 32'(exp_valid));
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(exp_overrun));
    checkOutput({tag, ".fe_cycles"}, 32'(fe_cycles), 32'(exp_fe_frame));
    checkOutput({tag, ".valid_rises"}, 32'(valid_rises), 32'(exp_rise_frame));
    checkOutput({tag, ".busy_end"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic ackByte(input string tag);
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    checkOutput({tag, ".ack_valid"}, 32'(data_valid), 32'(exp_valid));
    checkOutput({tag, ".ack_overrun"}, 32'(overrun), 32'(exp_overrun));
  endtask

  initial begin
    logic [7:0] rb;
    bit         rstop;
    bit         rack;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst.data", 32'(data_out), 32'h00);
    checkOutput("rst.valid", 32'(data_valid), 32'd0);
    checkOutput("rst.overrun", 32'(overrun), 32'd0);
    checkOutput("rst.frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst.busy", 32'(rx_busy), 32'd0);
    reset = 1'b1;
    idleClocks(20, 1'b1);

    $display("[TB] good byte 0xA5 with latency check");
    clearMonitor();
    applyStimulus(8'hA5, 1'b1, 1'b0, FRAME_CLKS);
    modelFrame(8'hA5, 1'b1, 1'b0);
    checkFrame("t1");
    checkOutput("t1.latency", 32'(valid_rise_cyc - frame_start_cyc), 32'(LATENCY));
    ackByte("t1");
    idleClocks(50, 1'b1);

    $display("[TB] start-bit glitch");
    clearMonitor();
    idleClocks(40, 1'b0);
    checkOutput("t2.busy_during", 32'(rx_busy), 32'd1);
    idleClocks(200, 1'b1);
    exp_fe_frame   = 0;
    exp_rise_frame = 0;
    checkFrame("t2");

    $display("[TB] framing error then break");
    clearMonitor();
    applyStimulus(8'h3C, 1'b0, 1'b0, FRAME_CLKS);
    modelFrame(8'h3C, 1'b0, 1'b0);
    checkFrame("t3");
    clearMonitor();
    idleClocks(500, 1'b0);
    checkOutput("t3.break_busy", 32'(busy_cycles), 32'd0);
    checkOutput("t3.break_fe", 32'(fe_cycles), 32'd0);
    idleClocks(100, 1'b1);

    $display("[TB] overrun");
    clearMonitor();
    applyStimulus(8'h11, 1'b1, 1'b0, FRAME_CLKS);
    modelFrame(8'h11, 1'b1, 1'b0);
    checkFrame("t4a");
    idleClocks(60, 1'b1);
    clearMonitor();
    applyStimulus(8'h22, 1'b1, 1'b0, FRAME_CLKS);
    modelFrame(8'h22, 1'b1, 1'b0);
    checkFrame("t4b");
    ackByte("t4");
    idleClocks(60, 1'b1);

    $display("[TB] ack coincident with completion");
    clearMonitor();
    applyStimulus(8'h55, 1'b1, 1'b0, FRAME_CLKS);
    modelFrame(8'h55, 1'b1, 1'b0);
    checkFrame("t5a");
    idleClocks(60, 1'b1);
    clearMonitor();
    applyStimulus(8'h66, 1'b1, 1'b1, FRAME_CLKS);
    modelFrame(8'h66, 1'b1, 1'b1);
    checkFrame("t5b");
    ackByte("t5");
    idleClocks(60, 1'b1);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hF0, 1'b1, 1'b0, 5 * CLKS_PER_BIT + 80);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t6.rst_data", 32'(data_out), 32'h00);
    checkOutput("t6.rst_valid", 32'(data_valid), 32'd0);
    checkOutput("t6.rst_busy", 32'(rx_busy), 32'd0);
    checkOutput("t6.rst_fe", 32'(frame_err), 32'd0);
    reset       = 1'b1;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    clearMonitor();
    idleClocks(300, 1'b1);
    checkOutput("t6.idle_busy", 32'(busy_cycles), 32'd0);
    applyStimulus(8'h0F, 1'b1, 1'b0, FRAME_CLKS);
    modelFrame(8'h0F, 1'b1, 1'b0);
    checkFrame("t6");
    ackByte("t6");
    idleClocks(60, 1'b1);

    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rack  = rstop && ($urandom_range(0, 2) == 0);
      clearMonitor();
      applyStimulus(rb, rstop, rack, FRAME_CLKS);
      modelFrame(rb, rstop, rack);
      checkFrame($sformatf("rnd%0d", i));
      idleClocks($urandom_range(50, 300), 1'b1);
      if ($urandom_range(0, 1) == 1) ackByte($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
